regfile_16x16: RTL
==================

Name: regfile_16x16

Overview:
- Operand register file for the 16-bit MIPS datapath: 16 registers, each 16 bits wide.
- Two combinational read ports drive the RS/RT operand buses directly into the ALU's set-less-than, add and logic units.
- One synchronous write port is driven by writeback.
- Sits directly upstream of the 16-bit SLT comparator and the rest of the execute stage.

Parameters:
- DATA_W, 16, width of each register and of the read/write data buses.
- ADDR_W, 4, register address width; number of registers is 2**ADDR_W (16).

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST_N  input  1  reset, asynchronous assert, active-low; clears all registers.
- WE  input  1  write enable from writeback.
- WA  input  ADDR_W  write address.
- WD  input  DATA_W  write data.
- RA1  input  ADDR_W  read address, port 1 (rs field).
- RA2  input  ADDR_W  read address, port 2 (rt field).
- RS  output  DATA_W  read data, port 1; feeds ALU operand A.
- RT  output  DATA_W  read data, port 2; feeds ALU operand B.

Behaviour:
- Storage: regs[1..15], each DATA_W flops. Register 0 is not stored; it reads as 16'h0000.
- Reset: when RST_N is low, regs[1..15] clear to 16'h0000 immediately, with no clock edge needed.
  - RS and RT therefore read 0 for every address while in reset.
  - Deassertion takes effect on the next rising edge of CLK; RST_N is synchronised upstream.
- Write: on a rising CLK edge with RST_N=1, WE=1 and WA!=0, regs[WA] <= WD.
  - WE=1 with WA=0 is silently ignored; register 0 stays 0.
  - WE=0 means no state change.
- Read: RS = (RA1==0) ? 0 : regs[RA1], and RT likewise for RA2. Purely combinational, zero-cycle latency.
- Both ports may address the same register in the same cycle; both return identical data.
- Reset mid-write: if RST_N falls in the same cycle as a write, reset wins and the register ends at 0.
- No X propagation: every address 0..15 is valid, so there is no out-of-range case.
- Without the optional feature, a write and a read to the same address in the same cycle returns the OLD value. The new value is visible the cycle after the edge.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through bypass on each port. When WE=1, WA!=0 and WA==RA1, RS = WD in the same cycle, before the clock edge; the same applies to RT when WA==RA2.
  - This removes the WB-to-ID hazard.
  - Bypass is suppressed while RST_N=0.
- Undefined: no bypass, read-old-value semantics as in Behaviour; the hazard unit must insert one stall.

Decomposition:
- Shared header mips_defs.vh holds:
  - DATA_W and ADDR_W defaults.
  - The REG_ZERO address constant (4'd0).
  - The zero word constant (16'h0000), shared with the ALU and SLT units.
- One natural sub-module: regfile_read_port. It is instantiated twice and contains:
  - the zero-register mux;
  - the optional bypass compare/mux, under REGFILE_BYPASS_EN.
- The storage array and write logic stay in the top module.

Test Plan:
- Reset: hold RST_N=0, sweep RA1/RA2 over 0..15 -> RS=RT=16'h0000 for every address. Release reset, no writes -> still 0.
- Basic write/read: write 16'hBEEF to r5 and 16'h1234 to r9 on consecutive edges, then RA1=5, RA2=9 -> RS=16'hBEEF, RT=16'h1234. Both ports at r5 -> both 16'hBEEF.
- Zero register: WE=1, WA=0, WD=16'hFFFF for one edge, then RA1=0 -> RS=16'h0000. Confirm no other register changed.
- Same-cycle write/read: WE=1, WA=3, WD=16'h00A5, RA1=3, r3 previously 16'h0011.
  - Macro off -> RS=16'h0011 before the edge, 16'h00A5 after.
  - Macro on -> RS=16'h00A5 before the edge.
- Async reset mid-operation: fill r1..r15 with 16'hAAAA, then pulse RST_N low for 3 ns between edges -> all reads 0 immediately, with no clock edge. A write coincident with reset is dropped.
- SLT integration: write r1=16'h0003, r2=16'h0007. RA1=1, RA2=2 into the SLT unit -> LT_O=16'h0001. Swap addresses -> LT_O=16'h0000.

Source files
------------

// File: rtl/regfile_16x16_pkg.sv
// ---------------------------------------------------------------------------
// regfile_16x16_pkg
// Shared constants for the 16-bit MIPS datapath: default bus widths, the
// hard-wired zero register address and the all-zero word. The ALU and SLT
// units use the same constants.
// No ports (package).
// ---------------------------------------------------------------------------
package regfile_16x16_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 4;

  localparam logic [3:0]  REG_ZERO  = 4'd0;
  localparam logic [15:0] ZERO_WORD = 16'h0000;

endpackage

// File: rtl/regfile_16x16_read_port.sv
// ---------------------------------------------------------------------------
// regfile_read_port
// One combinational read port of the register file. It forces address 0 to
// read as zero. When REGFILE_BYPASS_EN is defined, it also forwards the
// write data of an in-flight write to the same address, so writeback-to-
// decode needs no stall.
//
// Ports:
//   i_rst_n  reset, active-low; a low level suppresses the bypass
//   i_ra     read address
//   i_rdata  stored contents of register i_ra (don't care for address 0)
//   i_we     write enable of the write port
//   i_wa     write address of the write port
//   i_wd     write data of the write port
//   o_rd     read data
//
// Macro: REGFILE_BYPASS_EN enables write-through forwarding.
// ---------------------------------------------------------------------------
module regfile_read_port
  import regfile_16x16_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] i_ra,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_wa,
  input  logic [DATA_W-1:0] i_wd,
  output logic [DATA_W-1:0] o_rd
);

  logic [DATA_W-1:0] w_sel;

  assign w_sel = (i_ra == ADDR_W'(REG_ZERO)) ? DATA_W'(ZERO_WORD) : i_rdata;

`ifdef REGFILE_BYPASS_EN
  logic w_hit;

  // A write to r0 is discarded, so it must never be forwarded either.
  assign w_hit = i_rst_n && i_we && (i_wa != ADDR_W'(REG_ZERO)) && (i_wa == i_ra);
  assign o_rd  = w_hit ? i_wd : w_sel;
`else
  logic w_unused;

  // Write-port signals only matter when forwarding is built in.
  assign w_unused = ^{i_rst_n, i_we, i_wa, i_wd};
  assign o_rd     = w_sel;
`endif

endmodule

// File: rtl/regfile_16x16.sv
// ---------------------------------------------------------------------------
// regfile_16x16
// Operand register file for the 16-bit MIPS datapath. It has 16 registers of
// 16 bits. r0 is not stored and always reads zero. There are two
// combinational read ports (RS/RT) and one synchronous write port driven by
// writeback. An asynchronous active-low reset clears all stored registers.
//
// Ports:
//   CLK    system clock, rising edge
//   RST_N  asynchronous reset, active-low
//   WE     write enable
//   WA     write address
//   WD     write data
//   RA1    read address, port 1 (rs)
//   RA2    read address, port 2 (rt)
//   RS     read data, port 1 (ALU operand A)
//   RT     read data, port 2 (ALU operand B)
//
// Macro: REGFILE_BYPASS_EN turns on write-through forwarding in both read
// ports. Without it, a same-cycle read returns the old value.
// ---------------------------------------------------------------------------
module regfile_16x16
  import regfile_16x16_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              WE,
  input  logic [ADDR_W-1:0] WA,
  input  logic [DATA_W-1:0] WD,
  input  logic [ADDR_W-1:0] RA1,
  input  logic [ADDR_W-1:0] RA2,
  output logic [DATA_W-1:0] RS,
  output logic [DATA_W-1:0] RT
);

  localparam int unsigned NREGS = 2 ** ADDR_W;

  // Only r1..r(NREGS-1) hold state.
  logic [DATA_W-1:0] r_regs [NREGS-1:1];
  logic [DATA_W-1:0] w_rdata1;
  logic [DATA_W-1:0] w_rdata2;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 1; i < NREGS; i++) begin
        r_regs[i] <= DATA_W'(ZERO_WORD);
      end
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (WE && (WA == ADDR_W'(i))) begin
          r_regs[i] <= WD;
        end
      end
    end
  end

  // Address 0 selects nothing here; the read port substitutes zero.
  always_comb begin
    w_rdata1 = DATA_W'(ZERO_WORD);
    w_rdata2 = DATA_W'(ZERO_WORD);
    for (int i = 1; i < NREGS; i++) begin
      if (RA1 == ADDR_W'(i)) w_rdata1 = r_regs[i];
      if (RA2 == ADDR_W'(i)) w_rdata2 = r_regs[i];
    end
  end

  regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_port_rs (
    .i_rst_n (RST_N),
    .i_ra    (RA1),
    .i_rdata (w_rdata1),
    .i_we    (WE),
    .i_wa    (WA),
    .i_wd    (WD),
    .o_rd    (RS)
  );

  regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_port_rt (
    .i_rst_n (RST_N),
    .i_ra    (RA2),
    .i_rdata (w_rdata2),
    .i_we    (WE),
    .i_wa    (WA),
    .i_wd    (WD),
    .o_rd    (RT)
  );

endmodule
